arb_requester: RTL and testbench
================================

Name: arb_requester

Overview:
Client-side initiator for the two-port request/grant arbiter: one instance sits on each arbiter port (req_0/gnt_0 or req_1/gnt_1).
- Accepts a burst command (length, start address) from local logic.
- Raises req and waits for gnt.
- Drives an address-beat stream with a valid/ready handshake while it holds the grant.
- Drops req for one cycle after the burst so the arbiter returns to IDLE and can serve the other port.

Parameters:
LEN_W, 4, width of burst length; max burst = 2^LEN_W-1 beats
ADDR_W, 8, width of beat address
TIMEOUT, 16, grant-wait limit in cycles (used only with REQ_TIMEOUT_EN)

Ports:
clock  input  1  system clock, rising edge
reset_n  input  1  asynchronous, active-low reset
start  input  1  burst command strobe, honoured only in IDLE
start_len  input  LEN_W  beats in burst; 0 = command ignored
start_addr  input  ADDR_W  address of first beat
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse after the last beat is accepted
err  output  1  one-cycle pulse on abort (grant lost or timeout)
req  output  1  to arbiter req_x; registered, decoded from state
gnt  input  1  from arbiter gnt_x; combinational on the arbiter side
bus_valid  output  1  beat valid
bus_addr  output  ADDR_W  current beat address
bus_last  output  1  high with the final beat of the burst
bus_ready  input  1  sink accepts beat

Behaviour:
- Reset (reset_n low, async): state=IDLE; req, busy, done, err, bus_valid, bus_last = 0; bus_addr = 0; counters = 0.
- All state changes happen on the rising clock edge; outputs are registered or decoded from state only, with no combinational path from gnt to req.
- Beat transfer: a beat transfers in a cycle where bus_valid & bus_ready & gnt.
- IDLE:
  - req=0, bus_valid=0.
  - start=1 and start_len!=0: capture len and addr, go to REQ.
  - start_len=0: command dropped, no done or err.
- REQ:
  - req=1, busy=1, bus_valid=0.
  - gnt sampled high at a clock edge: go to XFER with remaining count = len.
- XFER:
  - req=1, bus_valid=1, bus_addr = current address, bus_last = (remaining==1).
  - On each beat transfer: address increments mod 2^ADDR_W (wraps silently) and remaining count decrements.
  - Transfer of the last beat: done pulses in the following cycle; go to RELEASE.
  - bus_ready low: hold bus_addr and bus_last stable, no decrement.
  - gnt low in XFER (arbiter reset or glitch): no transfer that cycle, err pulses, go to RELEASE; remaining beats are discarded.
- RELEASE:
  - req=0, bus_valid=0, busy=1 for exactly one cycle, then IDLE.
  - Guarantees the arbiter sees req low and is free to grant the other port.
- Latency:
  - start at edge k: req high from edge k.
  - Idle arbiter grants in the same cycle, so XFER starts at edge k+1 and the first beat is offered at k+1.
  - Minimum command-to-command spacing is len+3 cycles.
- start while busy: ignored, no queueing.
- done and err are never asserted together.
- reset_n asserted mid-burst: immediate return to IDLE, req drops asynchronously, no done or err.

Optional Feature:
REQ_TIMEOUT_EN
- Defined:
  - A wait counter clears on entering REQ and increments each cycle in REQ without gnt.
  - When it reaches TIMEOUT-1 with gnt still low: err pulses and the block goes to RELEASE.
  - A grant seen in the same cycle wins over the timeout.
- Undefined: REQ waits for gnt indefinitely; the counter logic is absent.

Test Plan:
- Idle arbiter, start, len=3, addr=0x10, bus_ready=1 -> req high the next cycle; beats 0x10, 0x11, 0x12 on consecutive cycles; bus_last on 0x12; done one cycle later; req low one cycle; busy low afterwards.
- len=2, bus_ready toggling 1,0,0,1 -> addr held during stall cycles; exactly 2 beats transfer; done follows the second accept.
- Two instances on arbiter ports 0/1, both start len=4 in the same cycle -> port 0 gets all 4 beats first; after its RELEASE cycle, port 1 gets its grant and all 4 beats; grants never overlap.
- Force gnt low after beat 2 of len=5 -> err pulses once, no done, req low for one cycle, then IDLE.
- With REQ_TIMEOUT_EN, TIMEOUT=16, gnt held low -> err at the 16th REQ cycle, then RELEASE and IDLE. Without the macro -> stays in REQ, busy=1 indefinitely.
- Assert reset_n low mid-XFER, between clock edges -> req, bus_valid, busy go low immediately. start with len=0 -> busy stays 0, no pulses. addr=0xFF, len=2 -> beat addresses 0xFF then 0x00.

Source files
------------

// File: rtl/arb_requester_if.sv
// rtl/arb_requester_if.sv - arbiter request/grant port plus address-beat stream of one requester
interface arb_requester_if #(
   parameter int ADDR_W = 8
);
   logic              req;
   logic              gnt;
   logic              bus_valid;
   logic [ADDR_W-1:0] bus_addr;
   logic              bus_last;
   logic              bus_ready;

   modport master (
      output req,
      input  gnt,
      output bus_valid,
      output bus_addr,
      output bus_last,
      input  bus_ready
   );

   modport slave (
      input  req,
      output gnt,
      input  bus_valid,
      input  bus_addr,
      input  bus_last,
      output bus_ready
   );
endinterface

// File: rtl/arb_requester.sv
// rtl/arb_requester.sv - burst requester for one port of the two-port request/grant arbiter
// Defining REQ_TIMEOUT_EN adds an abort when the grant does not arrive within TIMEOUT cycles.
module arb_requester #(
   parameter int LEN_W   = 4,
   parameter int ADDR_W  = 8,
   parameter int TIMEOUT = 16
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              start,
   input  logic [LEN_W-1:0]  start_len,
   input  logic [ADDR_W-1:0] start_addr,
   output logic              busy,
   output logic              done,
   output logic              err,
   arb_requester_if.master   bus
);
   typedef enum logic [1:0] {IDLE, REQ, XFER, RELEASE} state_t;

   state_t           state;
   logic [LEN_W-1:0] remaining;

`ifdef REQ_TIMEOUT_EN
   localparam int WAIT_W = $clog2(TIMEOUT + 1);
   logic [WAIT_W-1:0] wait_cnt;
`endif

   if (TIMEOUT < 1) begin : g_bad_timeout
      $error("TIMEOUT must be at least 1");
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state         <= IDLE;
         remaining     <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
         err           <= 1'b0;
         bus.req       <= 1'b0;
         bus.bus_valid <= 1'b0;
         bus.bus_addr  <= '0;
         bus.bus_last  <= 1'b0;
`ifdef REQ_TIMEOUT_EN
         wait_cnt      <= '0;
`endif
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         case (state)
            IDLE: begin
               if (start && start_len != '0) begin
                  remaining    <= start_len;
                  bus.bus_addr <= start_addr;
                  bus.req      <= 1'b1;
                  busy         <= 1'b1;
                  state        <= REQ;
`ifdef REQ_TIMEOUT_EN
                  wait_cnt     <= '0;
`endif
               end
            end
            REQ: begin
               if (bus.gnt) begin
                  bus.bus_valid <= 1'b1;
                  bus.bus_last  <= (remaining == LEN_W'(1));
                  state         <= XFER;
               end
`ifdef REQ_TIMEOUT_EN
               else if (wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
                  err     <= 1'b1;
                  bus.req <= 1'b0;
                  state   <= RELEASE;
               end else begin
                  wait_cnt <= wait_cnt + WAIT_W'(1);
               end
`endif
            end
            XFER: begin
               // Losing the grant mid-burst discards the remaining beats.
               if (!bus.gnt) begin
                  err           <= 1'b1;
                  bus.req       <= 1'b0;
                  bus.bus_valid <= 1'b0;
                  bus.bus_last  <= 1'b0;
                  state         <= RELEASE;
               end else if (bus.bus_ready) begin
                  if (remaining == LEN_W'(1)) begin
                     done          <= 1'b1;
                     bus.req       <= 1'b0;
                     bus.bus_valid <= 1'b0;
                     bus.bus_last  <= 1'b0;
                     state         <= RELEASE;
                  end else begin
                     bus.bus_addr <= bus.bus_addr + ADDR_W'(1);
                     bus.bus_last <= (remaining == LEN_W'(2));
                  end
                  remaining <= remaining - LEN_W'(1);
               end
            end
            RELEASE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_arb_requester.sv
// tb/tb_arb_requester.sv - directed bench: two requesters sharing a two-port arbiter model
module tb_arb_requester;
   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic       start0 = 1'b0, start1 = 1'b0;
   logic [3:0] len0 = '0, len1 = '0;
   logic [7:0] addr0 = '0, addr1 = '0;
   logic       busy0, done0, err0, busy1, done1, err1;
   logic       ready0 = 1'b1, ready1 = 1'b1;
   logic       kill = 1'b0;
   logic       arb_gnt0, arb_gnt1;
   int         passed = 0;
   int         total = 0;

   arb_requester_if #(.ADDR_W(8)) if0 ();
   arb_requester_if #(.ADDR_W(8)) if1 ();

   arb_requester #(.LEN_W(4), .ADDR_W(8), .TIMEOUT(16)) u0 (
      .clock(clock), .reset_n(reset_n), .start(start0), .start_len(len0),
      .start_addr(addr0), .busy(busy0), .done(done0), .err(err0), .bus(if0.master)
   );
   arb_requester #(.LEN_W(4), .ADDR_W(8), .TIMEOUT(16)) u1 (
      .clock(clock), .reset_n(reset_n), .start(start1), .start_len(len1),
      .start_addr(addr1), .busy(busy1), .done(done1), .err(err1), .bus(if1.master)
   );

   always #5 clock = ~clock;

   // Two-port arbiter: port 0 wins ties, owner keeps the grant while its req stays high.
   typedef enum logic [1:0] {A_IDLE, A_OWN0, A_OWN1} arb_t;
   arb_t arb;
   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) arb <= A_IDLE;
      else case (arb)
         A_IDLE:  arb <= if0.req ? A_OWN0 : (if1.req ? A_OWN1 : A_IDLE);
         A_OWN0:  arb <= if0.req ? A_OWN0 : A_IDLE;
         A_OWN1:  arb <= if1.req ? A_OWN1 : A_IDLE;
         default: arb <= A_IDLE;
      endcase
   end
   assign arb_gnt0 = (arb == A_IDLE) ? if0.req : ((arb == A_OWN0) && if0.req);
   assign arb_gnt1 = (arb == A_IDLE) ? (if1.req && !if0.req) : ((arb == A_OWN1) && if1.req);
   assign if0.gnt = arb_gnt0 && !kill;
   assign if1.gnt = arb_gnt1;
   assign if0.bus_ready = ready0;
   assign if1.bus_ready = ready1;

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset;
      #1;
      total++; if ({if0.req, busy0, done0, err0, if0.bus_valid, if0.bus_last} !== 6'b0)
         $display("FAIL reset_ctrl got %b want 000000", {if0.req, busy0, done0, err0, if0.bus_valid, if0.bus_last});
      else passed++;
      total++; if (if0.bus_addr !== 8'h00) $display("FAIL reset_addr got %h want 00", if0.bus_addr);
      else passed++;
      #11 reset_n = 1'b1;
      tick();
   endtask

   task automatic test_basic;
      start0 = 1'b1; len0 = 4'd3; addr0 = 8'h10;
      tick();
      start0 = 1'b0;
      total++; if ({if0.req, busy0, if0.bus_valid} !== 3'b110)
         $display("FAIL basic_req got %b want 110", {if0.req, busy0, if0.bus_valid});
      else passed++;
      for (int i = 0; i < 3; i++) begin
         tick();
         total++; if ({if0.bus_valid, if0.req, if0.bus_last, done0} !== {2'b11, (i == 2), 1'b0})
            $display("FAIL basic_beat%0d_ctrl got %b want %b", i, {if0.bus_valid, if0.req, if0.bus_last, done0}, {2'b11, (i == 2), 1'b0});
         else passed++;
         total++; if (if0.bus_addr !== 8'h10 + 8'(i))
            $display("FAIL basic_beat%0d_addr got %h want %h", i, if0.bus_addr, 8'h10 + 8'(i));
         else passed++;
      end
      tick();
      total++; if ({done0, err0, if0.req, if0.bus_valid, busy0} !== 5'b10001)
         $display("FAIL basic_release got %b want 10001", {done0, err0, if0.req, if0.bus_valid, busy0});
      else passed++;
      tick();
      total++; if ({done0, if0.req, busy0} !== 3'b000)
         $display("FAIL basic_idle got %b want 000", {done0, if0.req, busy0});
      else passed++;
   endtask

   task automatic test_stall;
      logic [3:0] pat;
      pat = 4'b1001;
      start0 = 1'b1; len0 = 4'd2; addr0 = 8'h40;
      tick();
      start0 = 1'b0;
      tick();
      total++; if ({if0.bus_valid, if0.bus_addr, if0.bus_last} !== {1'b1, 8'h40, 1'b0})
         $display("FAIL stall_first got %b/%h want 1/40", if0.bus_valid, if0.bus_addr);
      else passed++;
      for (int i = 0; i < 3; i++) begin
         ready0 = pat[3 - i];
         tick();
         total++; if ({if0.bus_valid, if0.bus_addr, if0.bus_last, done0} !== {1'b1, 8'h41, 1'b1, 1'b0})
            $display("FAIL stall_hold%0d got v=%b a=%h l=%b d=%b want 1/41/1/0", i, if0.bus_valid, if0.bus_addr, if0.bus_last, done0);
         else passed++;
      end
      ready0 = pat[0];
      tick();
      total++; if ({done0, if0.bus_valid} !== 2'b10)
         $display("FAIL stall_done got %b want 10", {done0, if0.bus_valid});
      else passed++;
      tick();
   endtask

   task automatic test_two_ports;
      int cnt0, cnt1, first0, first1, bad, overlap, dn0, dn1;
      cnt0 = 0; cnt1 = 0; first0 = -1; first1 = -1; bad = 0; overlap = 0; dn0 = 0; dn1 = 0;
      start0 = 1'b1; len0 = 4'd4; addr0 = 8'h20;
      start1 = 1'b1; len1 = 4'd4; addr1 = 8'h80;
      tick();
      start0 = 1'b0; start1 = 1'b0;
      for (int c = 0; c < 16; c++) begin
         if (if0.gnt && if1.gnt) overlap++;
         if (done0) dn0++;
         if (done1) dn1++;
         if (if0.bus_valid && ready0 && if0.gnt) begin
            if (first0 < 0) first0 = c;
            if (if0.bus_addr !== 8'h20 + 8'(cnt0) || if0.bus_last !== (cnt0 == 3)) bad++;
            cnt0++;
         end
         if (if1.bus_valid && ready1 && if1.gnt) begin
            if (first1 < 0) first1 = c;
            if (if1.bus_addr !== 8'h80 + 8'(cnt1) || if1.bus_last !== (cnt1 == 3)) bad++;
            cnt1++;
         end
         tick();
      end
      total++; if (cnt0 !== 4 || cnt1 !== 4) $display("FAIL two_beats got %0d/%0d want 4/4", cnt0, cnt1);
      else passed++;
      total++; if (first0 !== 1 || first1 !== 7) $display("FAIL two_order got %0d/%0d want 1/7", first0, first1);
      else passed++;
      total++; if (overlap !== 0 || bad !== 0) $display("FAIL two_overlap_addr got %0d/%0d want 0/0", overlap, bad);
      else passed++;
      total++; if (dn0 !== 1 || dn1 !== 1 || busy0 || busy1) $display("FAIL two_done got %0d/%0d busy %b%b want 1/1 00", dn0, dn1, busy0, busy1);
      else passed++;
   endtask

   task automatic test_grant_loss;
      start0 = 1'b1; len0 = 4'd5; addr0 = 8'h30;
      tick();
      start0 = 1'b0;
      tick();
      tick();
      tick();
      kill = 1'b1;
      total++; if (if0.bus_addr !== 8'h32) $display("FAIL loss_addr got %h want 32", if0.bus_addr);
      else passed++;
      tick();
      kill = 1'b0;
      total++; if ({err0, done0, if0.req, if0.bus_valid, busy0} !== 5'b10001)
         $display("FAIL loss_release got %b want 10001", {err0, done0, if0.req, if0.bus_valid, busy0});
      else passed++;
      tick();
      total++; if ({err0, done0, if0.req, busy0} !== 4'b0000)
         $display("FAIL loss_idle got %b want 0000", {err0, done0, if0.req, busy0});
      else passed++;
   endtask

   task automatic test_timeout;
      int early;
      early = 0;
      kill = 1'b1;
      start0 = 1'b1; len0 = 4'd1; addr0 = 8'h50;
      tick();
      start0 = 1'b0;
`ifdef REQ_TIMEOUT_EN
      for (int c = 0; c < 15; c++) begin
         tick();
         if (err0 || !if0.req || !busy0) early++;
      end
      total++; if (early !== 0) $display("FAIL timeout_early got %0d want 0", early);
      else passed++;
      tick();
      total++; if ({err0, done0, if0.req, busy0} !== 4'b1001)
         $display("FAIL timeout_err got %b want 1001", {err0, done0, if0.req, busy0});
      else passed++;
      tick();
      kill = 1'b0;
      total++; if ({err0, busy0} !== 2'b00) $display("FAIL timeout_idle got %b want 00", {err0, busy0});
      else passed++;
`else
      for (int c = 0; c < 40; c++) begin
         tick();
         if (err0 || !if0.req || !busy0 || if0.bus_valid) early++;
      end
      total++; if (early !== 0) $display("FAIL wait_forever got %0d want 0", early);
      else passed++;
      kill = 1'b0;
      tick();
      tick();
      total++; if (done0 !== 1'b1) $display("FAIL wait_late_done got %b want 1", done0);
      else passed++;
      tick();
`endif
   endtask

   task automatic test_async_reset;
      start0 = 1'b1; len0 = 4'd4; addr0 = 8'h60;
      tick();
      start0 = 1'b0;
      tick();
      #3 reset_n = 1'b0;
      #1;
      total++; if ({if0.req, if0.bus_valid, busy0, done0, err0} !== 5'b00000)
         $display("FAIL areset got %b want 00000", {if0.req, if0.bus_valid, busy0, done0, err0});
      else passed++;
      #2 reset_n = 1'b1;
      tick();
      total++; if ({busy0, done0, err0} !== 3'b000) $display("FAIL areset_after got %b want 000", {busy0, done0, err0});
      else passed++;
   endtask

   task automatic test_zero_len;
      start0 = 1'b1; len0 = 4'd0; addr0 = 8'h70;
      tick();
      start0 = 1'b0;
      total++; if ({busy0, if0.req} !== 2'b00) $display("FAIL zero_len got %b want 00", {busy0, if0.req});
      else passed++;
      tick();
      total++; if ({done0, err0, busy0} !== 3'b000) $display("FAIL zero_len_pulse got %b want 000", {done0, err0, busy0});
      else passed++;
   endtask

   task automatic test_wrap;
      start0 = 1'b1; len0 = 4'd2; addr0 = 8'hFF;
      tick();
      start0 = 1'b0;
      tick();
      total++; if ({if0.bus_addr, if0.bus_last} !== {8'hFF, 1'b0})
         $display("FAIL wrap_first got %h/%b want ff/0", if0.bus_addr, if0.bus_last);
      else passed++;
      tick();
      total++; if ({if0.bus_addr, if0.bus_last} !== {8'h00, 1'b1})
         $display("FAIL wrap_second got %h/%b want 00/1", if0.bus_addr, if0.bus_last);
      else passed++;
      tick();
      total++; if (done0 !== 1'b1) $display("FAIL wrap_done got %b want 1", done0);
      else passed++;
      tick();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_two_ports();
      test_grant_loss();
      test_timeout();
      test_async_reset();
      test_zero_len();
      test_wrap();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
